multibyte_add_seq: RTL
======================

# multibyte_add_seq

Sequencer that performs NBYTES-wide add/subtract by time-multiplexing a single 8-bit carry-lookahead adder (`cla8`), one byte per clock, LSB first. The block registers the carry between bytes and handles the operand/result shifting. It uses valid/ready handshakes on both sides. It sits between the ALU operand registers and the result bus, giving wide arithmetic at the cost of one 8-bit adder.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 2..8.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operands and op are valid.
- `in_ready` output, 1 bit: block can accept an operation; high only in IDLE.
- `op_sub` input, 1 bit: 0 selects A+B+cin, 1 selects A−B (cin ignored).
- `cin` input, 1 bit: carry-in for add.
- `A` input, 8·NBYTES bits: operand A.
- `B` input, 8·NBYTES bits: operand B.
- `out_valid` output, 1 bit: result and flags valid; held until accepted.
- `out_ready` input, 1 bit: consumer accepts the result.
- `Sum` output, 8·NBYTES bits: result.
- `Cout` output, 1 bit: carry out of the MSB; for subtract, 1 means no borrow.
- `ovf` output, 1 bit: signed overflow.
- `zero` output, 1 bit: Sum is all zeros.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. When `in_valid`=1 at an edge:
    - latch A into the A shift register.
    - latch B into the B shift register; for subtract, latch ~B.
    - set the carry register to `cin` for add, or to 1 for subtract.
    - clear the byte counter and go to RUN.
  - RUN:
    - `cla8` takes the low byte of each shift register and the carry register.
    - each edge: the Sum byte enters the MSB end of the result register, which shifts right by 8; the operand registers shift right by 8; the carry register takes the `cla8` Cout; the counter increments.
    - after the edge where counter = NBYTES−1, go to DONE.
  - DONE: `out_valid`=1. When `out_ready`=1, go to IDLE.
- Outputs `Sum`, `Cout`, `ovf` and `zero` are registered and stay stable while `out_valid`=1. They hold their last value in IDLE.
- Overflow is computed on the final byte, with a7 and b7 the operand MSBs (b already inverted for subtract) and s7 the result MSB: `ovf` = (a7 XNOR b7) AND (s7 XOR a7).
- `in_valid` is ignored outside IDLE. Operands are not re-sampled during RUN.
- `out_ready` is ignored outside DONE.
- No same-cycle turnaround: a new op is accepted no earlier than the cycle after the DONE→IDLE edge.
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0.
  - `Sum`=0, `Cout`=0, `ovf`=0, `zero`=0.
  - all shift registers, the carry register and the counter are 0.
- Reset mid-RUN or mid-DONE aborts the operation with no output.

## Timing
- Call the acceptance edge E0. Byte k is computed combinationally during cycle k and registered at edge E(k+1).
- `out_valid` rises after edge E(NBYTES), so latency is NBYTES cycles from acceptance to `out_valid`.
- Minimum issue interval is NBYTES+2 cycles (with `out_ready` tied high).
- `out_valid` stays high for at least 1 cycle and indefinitely under back-pressure.
- The critical path is one `cla8` plus the shift muxes. No combinational path runs from `in_valid` or `out_ready` to any output.

## Configuration
- `MULTIBYTE_ADD_FLAGS_EN` defined:
  - `ovf` and `zero` are computed and registered as above.
  - `zero` is the NOR of all result bytes, accumulated per byte during RUN (no wide reduction at the end).
- Macro undefined:
  - `ovf` and `zero` are tied to 0 and their flops are removed.
  - `Sum`, `Cout` and all timing are unchanged.

## Structure
- Shared package / header `alu_pkg` holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - the op encoding constants (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module: the existing `cla8` adder, instantiated once.
- The controller (FSM, counter, shift and carry registers) is flat in `multibyte_add_seq`; roughly 150–250 lines.

## Test plan
- NBYTES=4, add 0x000000FF + 0x00000001, cin=0 → Sum=0x00000100, Cout=0, ovf=0, zero=0; `out_valid` exactly 4 cycles after acceptance.
- Add 0xFFFFFFFF + 0x00000000, cin=1 → Sum=0, Cout=1, zero=1, ovf=0. This checks full carry ripple across all bytes.
- Subtract 0x80000000 − 0x00000001 → Sum=0x7FFFFFFF, Cout=1, ovf=1. Subtract 0x00000005 − 0x00000007 → Sum=0xFFFFFFFE, Cout=0, ovf=0.
- Hold `out_ready`=0 for 10 cycles and toggle `in_valid`/A → outputs stable, `in_ready`=0, no new op accepted. Then release: IDLE next cycle, then the new op is accepted.
- Assert `rst` for 1 cycle while the counter=2 → next cycle IDLE, `out_valid`=0, outputs 0. A subsequent op completes correctly.
- Build without `MULTIBYTE_ADD_FLAGS_EN` and rerun the cases above → identical Sum/Cout and timing; `ovf`=`zero`=0 always.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer FSM state encodings and operation select constants.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups joined by group generate/propagate.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Carries into bits 0..3 of a nibble, all expressed directly from ci.
  function automatic logic [3:0] nib_carry(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;
  logic [1:0] gg;
  logic [1:0] gp;
  logic       c4;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg[0] = grp_gen(g[3:0], p[3:0]);
    gg[1] = grp_gen(g[7:4], p[7:4]);
    gp[0] = &p[3:0];
    gp[1] = &p[7:4];
    c4    = gg[0] | (gp[0] & cin);
    c     = {nib_carry(g[7:4], p[7:4], c4), nib_carry(g[3:0], p[3:0], cin)};
    cout  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    sum   = p ^ c;
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// NBYTES-wide add/subtract sequenced byte-serially, LSB first, through one cla8.
// Optional flags (ovf, zero) are built only when MULTIBYTE_ADD_FLAGS_EN is defined.
module multibyte_add_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   Sum,
  output logic                  Cout,
  output logic                  ovf,
  output logic                  zero
);

  localparam int         W    = BYTE_W * NBYTES;
  localparam int         RW   = W - BYTE_W;
  localparam logic [2:0] LAST = 3'(NBYTES - 1);

  state_t          state;
  logic [2:0]      cnt;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic [RW-1:0]   res_sr;   // bytes already computed; the byte in flight completes the word
  logic [RW-1:0]   res_next;
  logic            carry;
  logic [7:0]      s_byte;
  logic            c_out;
  logic            accept;
  logic            last;

  cla8 u_cla8 (
    .a    (a_sr[7:0]),
    .b    (b_sr[7:0]),
    .cin  (carry),
    .sum  (s_byte),
    .cout (c_out)
  );

  always_comb begin
    accept   = (state == IDLE) && in_valid;
    last     = (state == RUN) && (cnt == LAST);
    res_next = RW'({s_byte, res_sr} >> BYTE_W);
  end

  // NOTE: every register here uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= A;
            b_sr     <= (op_sub == OP_SUB) ? ~B : B;
            carry    <= (op_sub == OP_SUB) ? 1'b1 : cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> BYTE_W;
          b_sr   <= b_sr >> BYTE_W;
          carry  <= c_out;
          cnt    <= cnt + 3'd1;
          if (last) begin
            Sum       <= {s_byte, res_sr};
            Cout      <= c_out;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef MULTIBYTE_ADD_FLAGS_EN
  logic zero_acc;

  // zero is folded in byte by byte so no wide reduction sits behind the last adder pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_acc <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      zero_acc <= 1'b1;
    end else if (state == RUN) begin
      zero_acc <= zero_acc & ~|s_byte;
      if (last) begin
        ovf  <= (a_sr[7] ~^ b_sr[7]) & (s_byte[7] ^ a_sr[7]);
        zero <= zero_acc & ~|s_byte;
      end
    end
  end
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule
